// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: icache packet in, ready/stall back, two decode slots out.
// The icache side drives the master modport; the queue takes the slave modport.
interface fetch_queue_if #(
  parameter int MXLEN = 32
);
  logic               i_icache_fq_valid;
  logic [MXLEN-1:0]   i_icache_fq_pc;
  logic [127:0]       i_icache_fq_data;
  logic               o_fq_icache_ready;
  logic               o_fq_pcGen_stall;
  logic [1:0]         o_fq_dec_valid;
  logic [31:0]        o_fq_dec_inst0;
  logic [31:0]        o_fq_dec_inst1;
  logic [MXLEN-1:0]   o_fq_dec_pc0;
  logic [MXLEN-1:0]   o_fq_dec_pc1;
  logic               i_dec_fq_ready;

  modport master (
    output i_icache_fq_valid, i_icache_fq_pc, i_icache_fq_data, i_dec_fq_ready,
    input  o_fq_icache_ready, o_fq_pcGen_stall, o_fq_dec_valid,
           o_fq_dec_inst0, o_fq_dec_inst1, o_fq_dec_pc0, o_fq_dec_pc1
  );

  modport slave (
    input  i_icache_fq_valid, i_icache_fq_pc, i_icache_fq_data, i_dec_fq_ready,
    output o_fq_icache_ready, o_fq_pcGen_stall, o_fq_dec_valid,
           o_fq_dec_inst0, o_fq_dec_inst1, o_fq_dec_pc0, o_fq_dec_pc1
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: 4-slot packets in, up to 2 instructions/cycle out to decode.
// Optional FQ_STAT_EN adds o_fq_stall_cnt, a free-running count of pcGen stall cycles.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int MXLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  fetch_queue_if.slave  fq
`ifdef FQ_STAT_EN
  ,
  output logic [31:0]   o_fq_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [31:0]      r_inst [DEPTH];
  logic [MXLEN-1:0] r_pc   [DEPTH];

  logic [PW-1:0]    w_occ;
  logic             w_ready;
  logic [1:0]       w_valid;
  logic             w_enq;
  logic [1:0]       w_off;
  logic [2:0]       w_n_enq;
  logic [1:0]       w_n_deq;
  logic [3:0]       w_wr_en;
  logic [AW-1:0]    w_wr_idx [4];
  logic [AW-1:0]    w_rd_idx0;
  logic [AW-1:0]    w_rd_idx1;
  logic             w_unused;

  // Ready looks only at registered occupancy, so it has no input-to-output path.
  assign w_occ    = r_tail - r_head;
  assign w_ready  = (w_occ <= PW'(DEPTH - 4));
  assign w_off    = fq.i_icache_fq_pc[3:2];
  assign w_enq    = fq.i_icache_fq_valid & w_ready & ~i_flush;
  assign w_n_enq  = 3'd4 - {1'b0, w_off};
  assign w_n_deq  = (fq.i_dec_fq_ready & ~i_flush) ?
                    ({1'b0, w_valid[0]} + {1'b0, w_valid[1]}) : 2'b00;
  assign w_rd_idx0 = r_head[AW-1:0];
  assign w_rd_idx1 = r_head[AW-1:0] + AW'(1'b1);
  assign w_unused  = ^fq.i_icache_fq_pc[1:0];

  // Decode slot validity from occupancy.
  always_comb begin
    w_valid = 2'b11;
    if (w_occ == {PW{1'b0}}) begin
      w_valid = 2'b00;
    end else if (w_occ == PW'(1'b1)) begin
      w_valid = 2'b01;
    end else begin
      w_valid = 2'b11;
    end
  end

  // Live slots off..3 land at consecutive tail positions, wrapping modulo DEPTH.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_wr_en[k]  = w_enq & (2'(k) >= w_off);
      w_wr_idx[k] = r_tail[AW-1:0] + AW'(2'(k) - w_off);
    end
  end

  assign fq.o_fq_icache_ready = w_ready;
  assign fq.o_fq_pcGen_stall  = ~w_ready;
  assign fq.o_fq_dec_valid    = w_valid;
  assign fq.o_fq_dec_inst0    = w_valid[0] ? r_inst[w_rd_idx0] : 32'd0;
  assign fq.o_fq_dec_pc0      = w_valid[0] ? r_pc[w_rd_idx0]   : {MXLEN{1'b0}};
  assign fq.o_fq_dec_inst1    = w_valid[1] ? r_inst[w_rd_idx1] : 32'd0;
  assign fq.o_fq_dec_pc1      = w_valid[1] ? r_pc[w_rd_idx1]   : {MXLEN{1'b0}};

  // Pointer update; flush discards both the enqueue and the dequeue of its cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= {PW{1'b0}};
      r_tail <= {PW{1'b0}};
    end else if (i_flush) begin
      r_head <= {PW{1'b0}};
      r_tail <= {PW{1'b0}};
    end else begin
      r_head <= r_head + PW'(w_n_deq);
      if (w_enq) begin
        r_tail <= r_tail + PW'(w_n_enq);
      end else begin
        r_tail <= r_tail;
      end
    end
  end

  // Entry storage: each written entry gets its slot's instruction and aligned PC.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_inst[e] <= 32'd0;
        r_pc[e]   <= {MXLEN{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_en[k]) begin
          r_inst[w_wr_idx[k]] <= fq.i_icache_fq_data[32*k +: 32];
          r_pc[w_wr_idx[k]]   <= {fq.i_icache_fq_pc[MXLEN-1:4], 2'(k), 2'b00};
        end
      end
    end
  end

`ifdef FQ_STAT_EN
  logic [31:0] r_stall_cnt;

  // Stall-cycle counter; survives flush, wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (!w_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_fq_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue with a queue-based scoreboard of {inst, pc}.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int MXLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  fetch_queue_if #(.MXLEN(MXLEN)) fq_if ();

`ifdef FQ_STAT_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_stall_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .MXLEN(MXLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .fq      (fq_if)
`ifdef FQ_STAT_EN
    ,
    .o_fq_stall_cnt (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [1:0]  ev;
    logic [63:0] e0;
    logic [63:0] e1;
    n  = sb.size();
    ev = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
    e0 = (n > 0) ? sb[0] : 64'd0;
    e1 = (n > 1) ? sb[1] : 64'd0;
    chk("ready", 64'(fq_if.o_fq_icache_ready), 64'((DEPTH - n) >= 4));
    chk("stall", 64'(fq_if.o_fq_pcGen_stall), 64'((DEPTH - n) < 4));
    chk("valid", 64'(fq_if.o_fq_dec_valid), 64'(ev));
    chk("inst0", 64'(fq_if.o_fq_dec_inst0), 64'(e0[63:32]));
    chk("pc0",   64'(fq_if.o_fq_dec_pc0),   64'(e0[31:0]));
    chk("inst1", 64'(fq_if.o_fq_dec_inst1), 64'(e1[63:32]));
    chk("pc1",   64'(fq_if.o_fq_dec_pc1),   64'(e1[31:0]));
`ifdef FQ_STAT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall_cnt));
`endif
  endtask

  // One clock: check the outputs, drive inputs, advance the model, take the edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [127:0] data,
                       input logic dr, input logic fl);
    int n;
    int nd;
    bit acc;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    fq_if.i_icache_fq_valid = v;
    fq_if.i_icache_fq_pc    = pc;
    fq_if.i_icache_fq_data  = data;
    fq_if.i_dec_fq_ready    = dr;
    flush = fl;
    n   = sb.size();
    acc = v && ((DEPTH - n) >= 4) && !fl;
    nd  = (dr && !fl) ? ((n >= 2) ? 2 : n) : 0;
`ifdef FQ_STAT_EN
    if ((DEPTH - n) < 4) exp_stall_cnt = exp_stall_cnt + 32'd1;
`endif
    if (fl) begin
      sb.delete();
    end else begin
      repeat (nd) void'(sb.pop_front());
      if (acc) begin
        for (int k = int'(pc[3:2]); k < 4; k++) begin
          sb.push_back({data[32*k +: 32], pc[31:4], k[1:0], 2'b00});
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      rst_n = 1'b0;
      fq_if.i_icache_fq_valid = 1'($urandom);
      fq_if.i_icache_fq_pc    = $urandom;
      fq_if.i_icache_fq_data  = {$urandom, $urandom, $urandom, $urandom};
      fq_if.i_dec_fq_ready    = 1'($urandom);
      flush = 1'($urandom);
      @(posedge clk);
    end
    sb.delete();
`ifdef FQ_STAT_EN
    exp_stall_cnt = 32'd0;
`endif
  endtask

  function automatic logic [127:0] pkt(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0;
    flush = 1'b0;
    fq_if.i_icache_fq_valid = 1'b0;
    fq_if.i_icache_fq_pc    = 32'd0;
    fq_if.i_icache_fq_data  = 128'd0;
    fq_if.i_dec_fq_ready    = 1'b0;
`ifdef FQ_STAT_EN
    exp_stall_cnt = 32'd0;
`endif
    do_reset();

    // Aligned packet with decode draining; first cycle also checks reset outputs.
    cycle(1'b1, 32'h8000_0000, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);

    // Unaligned packet: only slots 2 and 3 enter.
    cycle(1'b1, 32'h8000_0008, pkt(32'h1100_0000), 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);

    // Fill to DEPTH, third packet refused, then drain.
    cycle(1'b1, 32'h8000_0100, pkt(32'h2200_0000), 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0110, pkt(32'h2300_0000), 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0120, pkt(32'h2400_0000), 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);

    // Occupancy 5, then flush colliding with a packet and a pop.
    cycle(1'b1, 32'h8000_020C, pkt(32'h3300_0000), 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0210, pkt(32'h3400_0000), 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0220, pkt(32'h3500_0000), 1'b1, 1'b1);
    cycle(1'b0, 32'd0, 128'd0, 1'b0, 1'b0);

    // Drive tail past DEPTH-1, then a single offset-3 entry after the wrap.
    cycle(1'b1, 32'h8000_0300, pkt(32'h4400_0000), 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0310, pkt(32'h4500_0000), 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_0324, pkt(32'h4600_0000), 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);
    cycle(1'b1, 32'h8000_033C, pkt(32'h4700_0000), 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);

    // Reset mid-operation drops contents.
    cycle(1'b1, 32'h8000_0400, pkt(32'h5500_0000), 1'b0, 1'b0);
    cycle(1'b1, 32'h8000_0404, pkt(32'h5600_0000), 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 32'd0, 128'd0, 1'b0, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      rpc = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
      cycle(1'($urandom), rpc, {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end
    repeat (6) cycle(1'b0, 32'd0, 128'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
